// File: rtl/rs_corrector_if.sv
// Signal bundle for rs_corrector: received byte stream, decoder results and corrected output.
// master drives the channel/decoder side; slave is the corrector itself.
interface rs_corrector_if;
  logic       din_val;
  logic       din_sop;
  logic       din_eop;
  logic [7:0] din;
  logic       dec_done;
  logic       dec_fail;
  logic [7:0] el1, el2, el3, el4;
  logic [7:0] ev1, ev2, ev3, ev4;
  logic [2:0] error_num;
  logic       dout_val;
  logic       dout_sop;
  logic       dout_eop;
  logic [7:0] dout;
  logic       dout_fail;
  logic       busy;
  logic       drop;
  logic       len_err;

  modport master (
    output din_val, din_sop, din_eop, din, dec_done, dec_fail,
    output el1, el2, el3, el4, ev1, ev2, ev3, ev4, error_num,
    input  dout_val, dout_sop, dout_eop, dout, dout_fail, busy, drop, len_err
  );

  modport slave (
    input  din_val, din_sop, din_eop, din, dec_done, dec_fail,
    input  el1, el2, el3, el4, ev1, ev2, ev3, ev4, error_num,
    output dout_val, dout_sop, dout_eop, dout, dout_fail, busy, drop, len_err
  );
endinterface

// File: rtl/rs_corrector.sv
// RS(255,247) receive-side correction buffer: stores a codeword, waits for the decoder,
// then replays the data bytes with the reported error values XOR-applied.
module rs_corrector #(
  parameter int unsigned nn = 255,
  parameter int unsigned kk = 247,
  parameter int unsigned tt = 4
) (
  input logic           clk,
  input logic           rst_n,
  rs_corrector_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRecv, StWait, StOut} state_e;

  localparam logic [8:0] NnW = 9'(nn);
  localparam logic [8:0] KkW = 9'(kk);

  state_e     state_q, state_d;
  logic [8:0] wcnt_q, wcnt_d;
  logic [8:0] rcnt_q, rcnt_d;
  logic [7:0] el_q [tt];
  logic [7:0] el_d [tt];
  logic [7:0] ev_q [tt];
  logic [7:0] ev_d [tt];
  logic [2:0] num_q, num_d;
  logic       fail_q, fail_d;
  logic       drop_q, drop_d;
  logic       len_err_q, len_err_d;
  logic       dout_val_q, dout_sop_q, dout_eop_q, dout_fail_q;
  logic [7:0] corr_q, corr_d;
  logic       issue;
  logic       we;
  logic [7:0] waddr;
  logic [7:0] mem [256];
  logic [7:0] ram_q;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    el_d      = el_q;
    ev_d      = ev_q;
    num_d     = num_q;
    fail_d    = fail_q;
    drop_d    = 1'b0;
    len_err_d = 1'b0;
    we        = 1'b0;
    waddr     = wcnt_q[7:0];
    unique case (state_q)
      StIdle: begin
        if (bus.din_val) begin
          if (bus.din_sop) begin
            we     = 1'b1;
            waddr  = 8'd0;
            wcnt_d = 9'd1;
            // A one-byte frame can never be a full codeword.
            if (bus.din_eop) len_err_d = 1'b1;
            else             state_d   = StRecv;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      StRecv: begin
        if (bus.din_val) begin
          we     = 1'b1;
          wcnt_d = wcnt_q + 9'd1;
          if (bus.din_sop) begin
            waddr     = 8'd0;
            wcnt_d    = 9'd1;
            len_err_d = 1'b1;
            if (bus.din_eop) state_d = StIdle;
          end else if (bus.din_eop) begin
            if (wcnt_q == NnW - 9'd1) begin
              state_d = StWait;
            end else begin
              len_err_d = 1'b1;
              state_d   = StIdle;
            end
          end else if (wcnt_q == NnW - 9'd1) begin
            len_err_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StWait: begin
        drop_d = bus.din_val;
        if (bus.dec_fail) begin
          fail_d  = 1'b1;
          num_d   = 3'd0;
          rcnt_d  = 9'd0;
          state_d = StOut;
        end else if (bus.dec_done) begin
          el_d[0] = bus.el1;
          el_d[1] = bus.el2;
          el_d[2] = bus.el3;
          el_d[3] = bus.el4;
          ev_d[0] = bus.ev1;
          ev_d[1] = bus.ev2;
          ev_d[2] = bus.ev3;
          ev_d[3] = bus.ev4;
          num_d   = (bus.error_num > 3'(tt)) ? 3'(tt) : bus.error_num;
          fail_d  = 1'b0;
          rcnt_d  = 9'd0;
          state_d = StOut;
        end
      end
      StOut: begin
        drop_d = bus.din_val;
        // rcnt == kk is the drain cycle while the last byte leaves the RAM.
        if (rcnt_q == KkW) state_d = StIdle;
        else               rcnt_d  = rcnt_q + 9'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign issue = (state_q == StOut) && (rcnt_q < KkW);

  // Parity positions never match since rcnt stays below kk while issuing.
  always_comb begin
    corr_d = '0;
    for (int unsigned i = 0; i < tt; i++) begin
      if ((i < 32'(num_q)) && ({1'b0, el_q[i]} == rcnt_q)) corr_d = corr_d ^ ev_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= bus.din;
    ram_q <= mem[rcnt_q[7:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      num_q       <= '0;
      fail_q      <= 1'b0;
      drop_q      <= 1'b0;
      len_err_q   <= 1'b0;
      dout_val_q  <= 1'b0;
      dout_sop_q  <= 1'b0;
      dout_eop_q  <= 1'b0;
      dout_fail_q <= 1'b0;
      corr_q      <= '0;
      for (int unsigned i = 0; i < tt; i++) begin
        el_q[i] <= '0;
        ev_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      num_q       <= num_d;
      fail_q      <= fail_d;
      drop_q      <= drop_d;
      len_err_q   <= len_err_d;
      dout_val_q  <= issue;
      dout_sop_q  <= issue && (rcnt_q == 9'd0);
      dout_eop_q  <= issue && (rcnt_q == KkW - 9'd1);
      dout_fail_q <= issue && fail_q;
      corr_q      <= corr_d;
      el_q        <= el_d;
      ev_q        <= ev_d;
    end
  end

  assign bus.dout_val  = dout_val_q;
  assign bus.dout_sop  = dout_sop_q;
  assign bus.dout_eop  = dout_eop_q;
  assign bus.dout_fail = dout_fail_q;
  assign bus.dout      = dout_val_q ? (ram_q ^ corr_q) : 8'd0;
  assign bus.busy      = (state_q == StWait) || (state_q == StOut);
  assign bus.drop      = drop_q;
  assign bus.len_err   = len_err_q;

endmodule

// File: tb/tb_rs_corrector.sv
// Scoreboard bench for rs_corrector: expected bytes are queued when the decoder result is
// driven and popped as the corrected stream comes out.
module tb_rs_corrector;

  localparam int NN = 255;
  localparam int KK = 247;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rs_corrector_if bus ();

  rs_corrector #(.nn(255), .kk(247), .tt(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int drop_cnt = 0;
  int len_cnt  = 0;
  int out_cnt  = 0;

  logic [7:0]  orig [NN];
  logic [7:0]  rx   [NN];
  logic [7:0]  expd [KK];
  logic [10:0] sb   [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [10:0] e;
    if (bus.drop)    drop_cnt++;
    if (bus.len_err) len_cnt++;
    if (bus.dout_val) begin
      out_cnt++;
      check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("out_byte", 32'({bus.dout, bus.dout_sop, bus.dout_eop, bus.dout_fail}), 32'(e));
      end
    end else begin
      check_eq("idle_flags", 32'({bus.dout_sop, bus.dout_eop, bus.dout_fail}), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input int n, input bit eop_last);
    for (int i = 0; i < n; i++) begin
      bus.din_val = 1'b1;
      bus.din_sop = (i == 0);
      bus.din_eop = eop_last && (i == n - 1);
      bus.din     = rx[i];
      tick();
    end
    bus.din_val = 1'b0;
    bus.din_sop = 1'b0;
    bus.din_eop = 1'b0;
  endtask

  // ls/vs pack el4..el1 / ev4..ev1 from msb to lsb.
  task automatic decode(input bit done, input bit fail, input logic [31:0] ls,
                        input logic [31:0] vs, input logic [2:0] num, input int delay,
                        input bit full);
    repeat (delay) tick();
    bus.dec_done  = done;
    bus.dec_fail  = fail;
    bus.el1 = ls[7:0];   bus.el2 = ls[15:8];  bus.el3 = ls[23:16]; bus.el4 = ls[31:24];
    bus.ev1 = vs[7:0];   bus.ev2 = vs[15:8];  bus.ev3 = vs[23:16]; bus.ev4 = vs[31:24];
    bus.error_num = num;
    for (int j = 0; j < KK; j++) sb.push_back({expd[j], j == 0, j == KK - 1, fail});
    tick();
    bus.dec_done = 1'b0;
    bus.dec_fail = 1'b0;
    check_eq("lat_t1_val", 32'(bus.dout_val), 32'd0);
    check_eq("busy_out", 32'(bus.busy), 32'd1);
    tick();
    check_eq("lat_first", 32'({bus.dout_val, bus.dout_sop}), 32'd3);
    if (full) begin
      repeat (KK - 1) tick();
      check_eq("lat_last", 32'({bus.dout_val, bus.dout_eop}), 32'd3);
      tick();
      check_eq("frame_end", 32'({bus.dout_val, bus.busy}), 32'd0);
      check_eq("sb_drained", 32'(sb.size()), 32'd0);
    end
  endtask

  task automatic load_clean();
    for (int i = 0; i < NN; i++) rx[i] = orig[i];
    for (int i = 0; i < KK; i++) expd[i] = orig[i];
  endtask

  task automatic clean_frame(input int delay);
    load_clean();
    send_bytes(NN, 1'b1);
    check_eq("busy_rise", 32'(bus.busy), 32'd1);
    decode(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, delay, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0, l0, o0, guard;
    bus.din_val = 1'b0; bus.din_sop = 1'b0; bus.din_eop = 1'b0; bus.din = 8'd0;
    bus.dec_done = 1'b0; bus.dec_fail = 1'b0; bus.error_num = 3'd0;
    bus.el1 = 8'd0; bus.el2 = 8'd0; bus.el3 = 8'd0; bus.el4 = 8'd0;
    bus.ev1 = 8'd0; bus.ev2 = 8'd0; bus.ev3 = 8'd0; bus.ev4 = 8'd0;
    for (int i = 0; i < NN; i++) orig[i] = (i < KK) ? 8'(KK - i) : 8'(i * 3 + 7);

    repeat (3) tick();
    check_eq("reset_vals", 32'({bus.dout_val, bus.dout_sop, bus.dout_eop, bus.dout_fail,
                                bus.busy, bus.drop, bus.len_err, bus.dout}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Stray byte in IDLE.
    d0 = drop_cnt;
    bus.din_val = 1'b1; bus.din = 8'h33;
    tick();
    bus.din_val = 1'b0;
    tick();
    check_eq("drop_idle", 32'(drop_cnt - d0), 32'd1);

    clean_frame(20);

    // Four errors in the data region.
    load_clean();
    rx[5] = 8'd0; rx[25] = 8'd10; rx[35] = 8'd11; rx[55] = 8'd32;
    send_bytes(NN, 1'b1);
    decode(1'b1, 1'b0, {8'd55, 8'd35, 8'd25, 8'd5},
           {8'd192 ^ 8'd32, 8'd212 ^ 8'd11, 8'd222 ^ 8'd10, 8'd242 ^ 8'd0}, 3'd4, 3, 1'b1);

    // Error reported in a parity byte leaves data untouched.
    load_clean();
    rx[250] = rx[250] ^ 8'h55;
    send_bytes(NN, 1'b1);
    decode(1'b1, 1'b0, {8'd0, 8'd0, 8'd0, 8'd250}, {8'd0, 8'd0, 8'd0, 8'h55}, 3'd1, 2, 1'b1);

    // Duplicate positions accumulate; el4 lies beyond error_num.
    load_clean();
    expd[10] = expd[10] ^ 8'hFF;
    expd[0]  = expd[0] ^ 8'h01;
    send_bytes(NN, 1'b1);
    decode(1'b1, 1'b0, {8'd100, 8'd0, 8'd10, 8'd10}, {8'hAA, 8'h01, 8'hF0, 8'h0F}, 3'd3, 1,
           1'b1);

    // error_num above four is clamped.
    load_clean();
    expd[1] ^= 8'h01; expd[2] ^= 8'h02; expd[3] ^= 8'h04; expd[4] ^= 8'h08;
    send_bytes(NN, 1'b1);
    decode(1'b1, 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'h08, 8'h04, 8'h02, 8'h01}, 3'd7, 4, 1'b1);

    // Decode failure: raw bytes with dout_fail.
    load_clean();
    rx[5] = 8'd0;
    expd[5] = 8'd0;
    send_bytes(NN, 1'b1);
    decode(1'b0, 1'b1, {8'd0, 8'd0, 8'd0, 8'd5}, {8'd0, 8'd0, 8'd0, 8'd242}, 3'd1, 5, 1'b1);

    // done and fail together take the fail path.
    send_bytes(NN, 1'b1);
    decode(1'b1, 1'b1, {8'd0, 8'd0, 8'd0, 8'd5}, {8'd0, 8'd0, 8'd0, 8'd242}, 3'd1, 5, 1'b1);

    // Short frame.
    load_clean();
    l0 = len_cnt; o0 = out_cnt;
    send_bytes(200, 1'b1);
    tick();
    check_eq("len_err_once", 32'(len_cnt - l0), 32'd1);
    check_eq("len_err_busy", 32'(bus.busy), 32'd0);
    repeat (5) tick();
    check_eq("len_err_noout", 32'(out_cnt - o0), 32'd0);
    clean_frame(7);

    // Input while waiting is dropped and never written.
    load_clean();
    send_bytes(NN, 1'b1);
    d0 = drop_cnt;
    for (int i = 0; i < 5; i++) rx[i] = 8'hEE;
    send_bytes(5, 1'b1);
    tick();
    check_eq("drop_wait", 32'(drop_cnt - d0), 32'd5);
    check_eq("busy_hold", 32'(bus.busy), 32'd1);
    decode(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 2, 1'b1);

    // Reset around output byte 100.
    load_clean();
    send_bytes(NN, 1'b1);
    o0 = out_cnt;
    decode(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 3, 1'b0);
    guard = 0;
    while ((out_cnt - o0 < 100) && (guard < 400)) begin
      tick();
      guard++;
    end
    check_eq("reach_byte100", 32'(out_cnt - o0 >= 100), 32'd1);
    rst_n = 1'b0;
    tick();
    check_eq("rst_mid_out", 32'({bus.dout_val, bus.busy, bus.dout}), 32'd0);
    sb.delete();
    rst_n = 1'b1;
    tick();
    clean_frame(4);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
